i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target.sv | 191 +++++++++++++++++++
 tb/tb_i2c_target.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target with an 8-bit register pointer.
// Bus pins are oversampled on clk_i; writes strobe out, reads come back combinationally.
`timescale 1ns/1ps
module i2c_target #(
  parameter logic [6:0] ADDRESS = 7'h40
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_we_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_t;

  state_t     r_state;
  logic [2:0] r_scl_q;
  logic [2:0] r_sda_q;
  logic [3:0] r_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_ptr;
  logic [7:0] r_wdata;
  logic       r_we;
  logic       r_oe;
  logic       r_rw;
  logic       r_ack;

  logic w_scl;
  logic w_scl_d;
  logic w_sda;
  logic w_sda_d;
  logic w_rise;
  logic w_fall;
  logic w_start;
  logic w_stop;

  assign w_scl   = r_scl_q[1];
  assign w_scl_d = r_scl_q[2];
  assign w_sda   = r_sda_q[1];
  assign w_sda_d = r_sda_q[2];
  assign w_rise  = w_scl & ~w_scl_d;
  assign w_fall  = ~w_scl & w_scl_d;
  assign w_start = w_scl & w_scl_d & ~w_sda & w_sda_d;
  assign w_stop  = w_scl & w_scl_d & w_sda & ~w_sda_d;

  assign sda_oe_o    = r_oe;
  assign reg_addr_o  = r_ptr;
  assign reg_wdata_o = r_wdata;
  assign reg_we_o    = r_we;
  assign busy_o      = (r_state != S_IDLE);

  // Two sync flops plus one history flop per pin; idle bus reads high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_scl_q <= 3'b111;
      r_sda_q <= 3'b111;
    end else begin
      r_scl_q <= {r_scl_q[1:0], scl_i};
      r_sda_q <= {r_sda_q[1:0], sda_i};
    end
  end

  // Protocol FSM: shift on SCL rise, drive SDA on SCL fall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_shift <= 8'h00;
      r_ptr   <= 8'h00;
      r_wdata <= 8'h00;
      r_we    <= 1'b0;
      r_oe    <= 1'b0;
      r_rw    <= 1'b0;
      r_ack   <= 1'b1;
    end else begin
      r_we <= 1'b0;
      if (w_start) begin
        r_state <= S_ADDR;
        r_cnt   <= 4'd0;
        r_oe    <= 1'b0;
      end else if (w_stop) begin
        r_state <= S_IDLE;
        r_oe    <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR, S_REG, S_WDATA: begin
            if (w_rise && r_cnt != 4'd8) begin
              r_shift <= {r_shift[6:0], w_sda};
              r_cnt   <= r_cnt + 4'd1;
              if (r_state == S_WDATA && r_cnt == 4'd7) begin
                r_wdata <= {r_shift[6:0], w_sda};
                r_we    <= 1'b1;
              end
            end else if (w_fall && r_cnt == 4'd8) begin
              r_cnt <= 4'd0;
              if (r_state == S_ADDR) begin
                if (r_shift[7:1] == ADDRESS) begin
                  r_oe    <= 1'b1;
                  r_rw    <= r_shift[0];
                  r_state <= S_ADDR_ACK;
                end else begin
                  r_state <= S_IGNORE;
                end
              end else if (r_state == S_REG) begin
                r_ptr   <= r_shift;
                r_oe    <= 1'b1;
                r_state <= S_REG_ACK;
              end else begin
                r_oe    <= 1'b1;
                r_state <= S_WDATA_ACK;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_fall) begin
              r_cnt <= 4'd0;
              if (r_rw) begin
                r_shift <= reg_rdata_i;
                r_oe    <= ~reg_rdata_i[7];
                r_state <= S_RDATA;
              end else begin
                r_oe    <= 1'b0;
                r_state <= S_REG;
              end
            end
          end
          S_REG_ACK: begin
            if (w_fall) begin
              r_oe    <= 1'b0;
              r_cnt   <= 4'd0;
              r_state <= S_WDATA;
            end
          end
          S_WDATA_ACK: begin
            if (w_fall) begin
              r_oe    <= 1'b0;
              r_cnt   <= 4'd0;
              r_ptr   <= r_ptr + 8'd1;
              r_state <= S_WDATA;
            end
          end
          S_RDATA: begin
            if (w_rise && r_cnt != 4'd8) begin
              r_cnt <= r_cnt + 4'd1;
            end else if (w_fall) begin
              if (r_cnt == 4'd8) begin
                r_oe    <= 1'b0;
                r_state <= S_RDATA_ACK;
              end else begin
                r_shift <= {r_shift[6:0], 1'b0};
                r_oe    <= ~r_shift[6];
              end
            end
          end
          S_RDATA_ACK: begin
            // Bump the pointer at the ACK rise so reg_rdata_i has
            // settled on the next byte by the following fall.
            if (w_rise) begin
              r_ack <= w_sda;
              if (!w_sda) r_ptr <= r_ptr + 8'd1;
            end else if (w_fall) begin
              r_cnt <= 4'd0;
              if (!r_ack) begin
                r_shift <= reg_rdata_i;
                r_oe    <= ~reg_rdata_i[7];
                r_state <= S_RDATA;
              end else begin
                r_oe    <= 1'b0;
                r_state <= S_IGNORE;
              end
            end
          end
          S_IDLE, S_IGNORE: r_oe <= 1'b0;
          default: begin
            r_oe    <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged controller on an open-drain SDA,
// write strobes and read bytes checked against queued expectations.
`timescale 1ns/1ps
module tb_i2c_target;

  localparam int T = 80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       sda_bus;

  assign sda_bus   = m_sda & ~sda_oe;
  assign reg_rdata = reg_addr + 8'h10;

  i2c_target #(.ADDRESS(7'h40)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .scl_i(m_scl),
    .sda_i(sda_bus),
    .sda_oe_o(sda_oe),
    .reg_addr_o(reg_addr),
    .reg_wdata_o(reg_wdata),
    .reg_we_o(reg_we),
    .reg_rdata_i(reg_rdata),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  int we_cnt = 0;
  logic oe_seen = 1'b0;
  logic [15:0] wr_q[$];
  logic [7:0]  rd_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Strobe scoreboard, sampled between clock edges.
  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (rst_n && reg_we) begin
      logic [15:0] e;
      we_cnt++;
      chk("we_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        e = wr_q.pop_front();
        chk("we_addr", 32'(reg_addr), 32'(e[15:8]));
        chk("we_data", 32'(reg_wdata), 32'(e[7:0]));
      end
    end
  end

  task automatic start_c();
    m_sda = 1'b1; #T;
    m_scl = 1'b1; #T;
    m_sda = 1'b0; #T;
    m_scl = 1'b0; #T;
  endtask

  task automatic stop_c();
    m_sda = 1'b0; #T;
    m_scl = 1'b1; #T;
    m_sda = 1'b1; #T;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      #(T/2) m_sda = b[i];
      #(T/2) m_scl = 1'b1;
      #T     m_scl = 1'b0;
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    #(T/2) m_sda = 1'b1;
    #(T/2) m_scl = 1'b1;
    #(T/2) ack = ~sda_bus;
    #(T/2) m_scl = 1'b0;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      #(T/2) m_sda = 1'b1;
      #(T/2) m_scl = 1'b1;
      #(T/2) b[i] = sda_bus;
      #(T/2) m_scl = 1'b0;
    end
    #(T/2) m_sda = nack;
    #(T/2) m_scl = 1'b1;
    #T     m_scl = 1'b0;
  endtask

  typedef struct {
    logic [7:0] dev;
    logic [7:0] rg;
    logic [7:0] d0;
    logic [7:0] d1;
    int         n;
    logic       ack;
    logic [7:0] ptr;
  } wvec_t;

  wvec_t tbl[4];

  initial begin
    logic       a;
    logic [7:0] b;
    logic [7:0] ra;
    int         wb;

    tbl[0] = '{8'h80, 8'h06, 8'hAB, 8'h00, 1, 1'b1, 8'h07};
    tbl[1] = '{8'h80, 8'hFF, 8'h11, 8'h22, 2, 1'b1, 8'h01};
    tbl[2] = '{8'h82, 8'h06, 8'hAB, 8'h00, 1, 1'b0, 8'h01};
    tbl[3] = '{8'h80, 8'h30, 8'h5A, 8'hC3, 2, 1'b1, 8'h32};

    #33;
    chk("rst_oe", 32'(sda_oe), 32'd0);
    chk("rst_ptr", 32'(reg_addr), 32'd0);
    chk("rst_wdata", 32'(reg_wdata), 32'd0);
    chk("rst_we", 32'(reg_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #T;

    for (int k = 0; k < 4; k++) begin
      wb = we_cnt;
      oe_seen = 1'b0;
      start_c();
      chk("busy_after_start", 32'(busy), 32'd1);
      write_byte(tbl[k].dev, a);
      chk("addr_ack", 32'(a), 32'(tbl[k].ack));
      if (tbl[k].ack) begin
        ra = tbl[k].rg;
        wr_q.push_back({ra, tbl[k].d0});
        ra = ra + 8'd1;
        if (tbl[k].n > 1) wr_q.push_back({ra, tbl[k].d1});
      end
      write_byte(tbl[k].rg, a);
      chk("reg_ack", 32'(a), 32'(tbl[k].ack));
      write_byte(tbl[k].d0, a);
      chk("d0_ack", 32'(a), 32'(tbl[k].ack));
      if (tbl[k].n > 1) begin
        write_byte(tbl[k].d1, a);
        chk("d1_ack", 32'(a), 32'(tbl[k].ack));
      end
      stop_c();
      #T;
      chk("busy_after_stop", 32'(busy), 32'd0);
      chk("ptr_after", 32'(reg_addr), 32'(tbl[k].ptr));
      chk("we_count", 32'(we_cnt - wb), tbl[k].ack ? 32'(tbl[k].n) : 32'd0);
      if (!tbl[k].ack) chk("no_oe_mismatch", 32'(oe_seen), 32'd0);
    end

    // Combined read with repeated START.
    start_c();
    write_byte(8'h80, a); chk("rd_addr_w_ack", 32'(a), 32'd1);
    write_byte(8'h06, a); chk("rd_reg_ack", 32'(a), 32'd1);
    start_c();
    write_byte(8'h81, a); chk("rd_addr_r_ack", 32'(a), 32'd1);
    rd_q.push_back(8'h16);
    rd_q.push_back(8'h17);
    read_byte(1'b0, b); chk("rd_byte0", 32'(b), 32'(rd_q.pop_front()));
    read_byte(1'b1, b); chk("rd_byte1", 32'(b), 32'(rd_q.pop_front()));
    stop_c();
    #T;
    chk("rd_busy", 32'(busy), 32'd0);
    chk("rd_ptr", 32'(reg_addr), 32'h07);

    // STOP after 4 data bits: partial byte dropped.
    wb = we_cnt;
    start_c();
    write_byte(8'h80, a); chk("ab_addr_ack", 32'(a), 32'd1);
    write_byte(8'h10, a); chk("ab_reg_ack", 32'(a), 32'd1);
    send_bits(8'hA5, 4);
    stop_c();
    #T;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_ptr", 32'(reg_addr), 32'h10);
    chk("ab_we", 32'(we_cnt - wb), 32'd0);

    // Reset while the address ACK is driven.
    start_c();
    send_bits(8'h80, 8);
    #(T/2) m_sda = 1'b1;
    #(T/2) m_scl = 1'b1;
    #(T/2);
    chk("ack_driven", 32'(sda_oe), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_oe", 32'(sda_oe), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_ptr", 32'(reg_addr), 32'd0);
    #T;
    m_scl = 1'b1;
    m_sda = 1'b1;
    #T;
    rst_n = 1'b1;
    #T;
    chk("post_rst_idle", 32'(busy), 32'd0);

    // Fresh transaction after reset.
    wb = we_cnt;
    wr_q.push_back({8'h44, 8'h99});
    start_c();
    write_byte(8'h80, a); chk("pr_addr_ack", 32'(a), 32'd1);
    write_byte(8'h44, a); chk("pr_reg_ack", 32'(a), 32'd1);
    write_byte(8'h99, a); chk("pr_d_ack", 32'(a), 32'd1);
    stop_c();
    #T;
    chk("pr_ptr", 32'(reg_addr), 32'h45);
    chk("pr_we", 32'(we_cnt - wb), 32'd1);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
